hazard_unit_md: RTL and testbench
=================================

Name: hazard_unit_md

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Compares D-stage source registers against E/M/W destinations using Tuse/Tnew timing and produces a D-stage stall plus per-operand forward selects.
- Owns a latency counter for the multi-cycle multiply/divide unit. Any HI/LO-using instruction in D is held while that unit is busy.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- RA_W, 5, register address width; address 0 is never a hazard.
- T_W, 2, width of all Tuse/Tnew fields.
- MULT_CYC, 5, busy cycles after a multiply start.
- DIV_CYC, 10, busy cycles after a divide start.
- MDC_W, 4, multiply/divide counter width; must hold max(MULT_CYC, DIV_CYC).
- PCNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- d_rs, d_rt  in  RA_W each  D-stage source register addresses.
- d_tuse_rs, d_tuse_rt  in  T_W each  cycles until the D instruction consumes the operand; all-ones means unused.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_dest, m_dest, w_dest  in  RA_W each  destination register of the E/M/W instruction.
- e_we, m_we, w_we  in  1 each  that stage writes the register file.
- e_tnew, m_tnew  in  T_W each  cycles until the stage's result is available, relative to that stage; W is always ready.
- md_start  in  1  the E instruction starts the multiply/divide unit this cycle.
- md_is_div  in  1  qualifies md_start: 1 = divide latency, 0 = multiply latency.
- stall  out  1  freeze PC and F/D, bubble D/E; combinational.
- fwd_rs_sel, fwd_rt_sel  out  2 each  0 = register file, 1 = E, 2 = M, 3 = W; combinational.
- md_busy  out  1  multiply/divide counter is nonzero; registered.
- stall_cnt  out  PCNT_W  saturating count of stalled cycles; registered.

Behaviour:
- Match on source s in {rs, rt} with stage X in {E, M, W}: x_we && x_dest == d_s && x_dest != 0.
- Data stall: (E match && d_tuse_s < e_tnew) || (M match && d_tuse_s < m_tnew). Compare unsigned at T_W bits. W never causes a stall.
- Multiply/divide stall: d_md_use && (md_start || md_busy).
- stall = OR of all data stalls and the multiply/divide stall.
- Forward select per operand, priority E > M > W > register file:
  - E: E match && e_tnew == 0 gives 1.
  - M: M match && m_tnew == 0 gives 2.
  - W: W match gives 3.
  - Otherwise 0.
  - An E match with e_tnew != 0 blocks lower-priority forwarding for that operand; select is 0 and stall covers it.
- Forward selects are computed regardless of stall.
- Multiply/divide counter (md_cnt, MDC_W bits), evaluated each clock:
  - reset gives 0.
  - Else if md_start: load DIV_CYC if md_is_div, else MULT_CYC. A start while busy reloads; no accumulation.
  - Else if md_cnt != 0: decrement by 1.
  - Else hold at 0.
- md_busy = (md_cnt != 0), taken from the register. A start sets md_busy from the next cycle. It stays high for exactly N cycles after the start cycle.
- Stall counter:
  - reset gives 0.
  - Else if stall and stall_cnt != all-ones: increment by 1.
  - Saturates at all-ones and holds.
- Reset values: md_cnt = 0, md_busy = 0, stall_cnt = 0. With all inputs 0 after reset, stall = 0 and fwd selects = 0.
- Reset asserted mid-count clears the counter on that edge; reset wins over md_start on the same edge.
- Simultaneous data stall and multiply/divide stall count as one stall cycle.

Test Plan:
- Load-use: e_dest=5, e_we=1, e_tnew=2, d_rs=5, d_tuse_rs=1 -> stall=1, fwd_rs_sel=0. Next cycle (E bubble), m_dest=5, m_tnew=1 -> stall=0, fwd_rs_sel=0. Following cycle, w_dest=5 -> fwd_rs_sel=3.
- ALU forward priority: e_dest=m_dest=8, both we=1, e_tnew=0, m_tnew=0, d_rt=8, d_tuse_rt=1 -> stall=0, fwd_rt_sel=1. Set e_we=0 -> fwd_rt_sel=2.
- $0 and branch: e_dest=0, e_tnew=1, d_rs=0, d_tuse_rs=0 -> stall=0, fwd=0. Set e_dest=d_rs=3 -> stall=1.
- Divide latency: md_start=1, md_is_div=1 for one cycle with DIV_CYC=10. md_busy is high for exactly 10 cycles, then 0. d_md_use=1 gives stall=1 from the start cycle through the last busy cycle. d_md_use=0 gives stall=0 throughout.
- Reset mid-operation: multiply start (MULT_CYC=5), assert reset on cycle 2 -> md_busy=0 and stall_cnt=0 next cycle. Reset together with md_start -> md_cnt stays 0.
- Counter saturation with PCNT_W=4: hold stall=1 for 20 cycles -> stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/hazard_unit_md.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline.
// Also tracks multiply/divide unit latency and counts stalled cycles.
module hazard_unit_md #(
   parameter int RA_W     = 5,
   parameter int T_W      = 2,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int MDC_W    = 4,
   parameter int PCNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RA_W-1:0]   d_rs,
   input  logic [RA_W-1:0]   d_rt,
   input  logic [T_W-1:0]    d_tuse_rs,
   input  logic [T_W-1:0]    d_tuse_rt,
   input  logic              d_md_use,
   input  logic [RA_W-1:0]   e_dest,
   input  logic [RA_W-1:0]   m_dest,
   input  logic [RA_W-1:0]   w_dest,
   input  logic              e_we,
   input  logic              m_we,
   input  logic              w_we,
   input  logic [T_W-1:0]    e_tnew,
   input  logic [T_W-1:0]    m_tnew,
   input  logic              md_start,
   input  logic              md_is_div,
   output logic              stall,
   output logic [1:0]        fwd_rs_sel,
   output logic [1:0]        fwd_rt_sel,
   output logic              md_busy,
   output logic [PCNT_W-1:0] stall_cnt
);

   logic [MDC_W-1:0] md_cnt;
   logic rs_e_match, rs_m_match, rs_w_match;
   logic rt_e_match, rt_m_match, rt_w_match;
   logic rs_data_stall, rt_data_stall, md_stall;

   // Register $0 is hardwired, so a write to it never creates a dependency.
   assign rs_e_match = e_we && (e_dest == d_rs) && (e_dest != '0);
   assign rs_m_match = m_we && (m_dest == d_rs) && (m_dest != '0);
   assign rs_w_match = w_we && (w_dest == d_rs) && (w_dest != '0);
   assign rt_e_match = e_we && (e_dest == d_rt) && (e_dest != '0);
   assign rt_m_match = m_we && (m_dest == d_rt) && (m_dest != '0);
   assign rt_w_match = w_we && (w_dest == d_rt) && (w_dest != '0);

   assign rs_data_stall = (rs_e_match && (d_tuse_rs < e_tnew)) ||
                          (rs_m_match && (d_tuse_rs < m_tnew));
   assign rt_data_stall = (rt_e_match && (d_tuse_rt < e_tnew)) ||
                          (rt_m_match && (d_tuse_rt < m_tnew));
   assign md_stall      = d_md_use && (md_start || md_busy);
   assign stall         = rs_data_stall || rt_data_stall || md_stall;

   // An E match whose result is not ready yet shadows older M/W copies.
   always_comb begin
      fwd_rs_sel = 2'd0;
      if (rs_e_match) begin
         if (e_tnew == '0) fwd_rs_sel = 2'd1;
      end else if (rs_m_match && (m_tnew == '0)) begin
         fwd_rs_sel = 2'd2;
      end else if (rs_w_match) begin
         fwd_rs_sel = 2'd3;
      end
   end

   always_comb begin
      fwd_rt_sel = 2'd0;
      if (rt_e_match) begin
         if (e_tnew == '0) fwd_rt_sel = 2'd1;
      end else if (rt_m_match && (m_tnew == '0)) begin
         fwd_rt_sel = 2'd2;
      end else if (rt_w_match) begin
         fwd_rt_sel = 2'd3;
      end
   end

   // A new start reloads the latency rather than adding to what remains.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt <= '0;
      end else if (md_start) begin
         md_cnt <= md_is_div ? MDC_W'(DIV_CYC) : MDC_W'(MULT_CYC);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - MDC_W'(1);
      end
   end

   assign md_busy = (md_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + PCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Self-checking bench for hazard_unit_md: directed pipeline scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_hazard_unit_md;

   localparam int RA_W     = 5;
   localparam int T_W      = 2;
   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;
   localparam int MDC_W    = 4;
   localparam int PCNT_W   = 4;
   localparam int CNT_MAX  = (1 << PCNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [RA_W-1:0]   d_rs, d_rt, e_dest, m_dest, w_dest;
   logic [T_W-1:0]    d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic              d_md_use, e_we, m_we, w_we, md_start, md_is_div;
   logic              stall, md_busy;
   logic [1:0]        fwd_rs_sel, fwd_rt_sel;
   logic [PCNT_W-1:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: cycle index, most recent multiply/divide start and its length.
   int cyc         = 0;
   int last_start  = 0;
   int last_len    = 0;
   bit start_valid = 1'b0;
   int exp_cnt     = 0;

   always #5 clk = ~clk;

   hazard_unit_md #(
      .RA_W(RA_W), .T_W(T_W), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC),
      .MDC_W(MDC_W), .PCNT_W(PCNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_md_use(d_md_use),
      .e_dest(e_dest), .m_dest(m_dest), .w_dest(w_dest),
      .e_we(e_we), .m_we(m_we), .w_we(w_we),
      .e_tnew(e_tnew), .m_tnew(m_tnew),
      .md_start(md_start), .md_is_div(md_is_div),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Busy for the len cycles following the start cycle.
   function automatic bit model_busy();
      return start_valid && ((cyc - last_start) <= last_len);
   endfunction

   function automatic int model_fwd(input int src);
      if (src == 0) return 0;
      if (e_we && int'(e_dest) == src) return (e_tnew == 0) ? 1 : 0;
      if (m_we && int'(m_dest) == src && m_tnew == 0) return 2;
      if (w_we && int'(w_dest) == src) return 3;
      return 0;
   endfunction

   function automatic bit model_stall();
      int src[2];
      int tuse[2];
      bit s;
      src[0] = int'(d_rs);  tuse[0] = int'(d_tuse_rs);
      src[1] = int'(d_rt);  tuse[1] = int'(d_tuse_rt);
      s = d_md_use && (md_start || model_busy());
      for (int k = 0; k < 2; k++) begin
         if (src[k] != 0) begin
            if (e_we && int'(e_dest) == src[k] && tuse[k] < int'(e_tnew)) s = 1'b1;
            if (m_we && int'(m_dest) == src[k] && tuse[k] < int'(m_tnew)) s = 1'b1;
         end
      end
      return s;
   endfunction

   // Called at a falling edge with inputs already driven; returns at the next one.
   task automatic applyStimulus();
      bit es;
      #1;
      es = model_stall();
      checkOutput("stall", stall, es);
      checkOutput("fwd_rs_sel", fwd_rs_sel, model_fwd(int'(d_rs)));
      checkOutput("fwd_rt_sel", fwd_rt_sel, model_fwd(int'(d_rt)));
      checkOutput("md_busy", md_busy, model_busy());
      checkOutput("stall_cnt", stall_cnt, exp_cnt);
      @(posedge clk);
      if (reset) begin
         start_valid = 1'b0;
         exp_cnt     = 0;
      end else begin
         if (es && exp_cnt < CNT_MAX) exp_cnt++;
         if (md_start) begin
            start_valid = 1'b1;
            last_start  = cyc;
            last_len    = md_is_div ? DIV_CYC : MULT_CYC;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clearInputs();
      d_rs = '0; d_rt = '0; d_tuse_rs = '1; d_tuse_rt = '1; d_md_use = 1'b0;
      e_dest = '0; m_dest = '0; w_dest = '0;
      e_we = 1'b0; m_we = 1'b0; w_we = 1'b0;
      e_tnew = '0; m_tnew = '0; md_start = 1'b0; md_is_div = 1'b0;
   endtask

   initial begin
      int nbusy;
      reset = 1'b1;
      clearInputs();
      d_tuse_rs = '0; d_tuse_rt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_fwd_rs", fwd_rs_sel, 0);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
      applyStimulus();

      // Load-use through E, then M bubble, then W forward.
      clearInputs();
      e_dest = 5'd5; e_we = 1'b1; e_tnew = 2'd2; d_rs = 5'd5; d_tuse_rs = 2'd1;
      #1;
      checkOutput("lu_stall", stall, 1);
      checkOutput("lu_fwd", fwd_rs_sel, 0);
      applyStimulus();
      e_we = 1'b0; m_dest = 5'd5; m_we = 1'b1; m_tnew = 2'd1;
      #1;
      checkOutput("lu_m_stall", stall, 0);
      checkOutput("lu_m_fwd", fwd_rs_sel, 0);
      applyStimulus();
      m_we = 1'b0; w_dest = 5'd5; w_we = 1'b1;
      #1;
      checkOutput("lu_w_fwd", fwd_rs_sel, 3);
      applyStimulus();

      // E beats M when both hold the newest value.
      clearInputs();
      e_dest = 5'd8; m_dest = 5'd8; e_we = 1'b1; m_we = 1'b1; d_rt = 5'd8; d_tuse_rt = 2'd1;
      #1;
      checkOutput("prio_stall", stall, 0);
      checkOutput("prio_e", fwd_rt_sel, 1);
      applyStimulus();
      e_we = 1'b0;
      #1;
      checkOutput("prio_m", fwd_rt_sel, 2);
      applyStimulus();

      // Register $0 never stalls a branch.
      clearInputs();
      e_we = 1'b1; e_tnew = 2'd1; d_tuse_rs = 2'd0;
      #1;
      checkOutput("zero_stall", stall, 0);
      checkOutput("zero_fwd", fwd_rs_sel, 0);
      applyStimulus();
      e_dest = 5'd3; d_rs = 5'd3;
      #1;
      checkOutput("br_stall", stall, 1);
      applyStimulus();

      // Divide latency with and without a dependent HI/LO user.
      for (int use_md = 1; use_md >= 0; use_md--) begin
         clearInputs();
         d_md_use = use_md[0]; md_start = 1'b1; md_is_div = 1'b1;
         #1;
         checkOutput("div_start_stall", stall, use_md);
         applyStimulus();
         md_start = 1'b0;
         nbusy = 0;
         for (int i = 0; i < DIV_CYC + 3; i++) begin
            #1;
            if (md_busy === 1'b1) nbusy++;
            applyStimulus();
         end
         checkOutput("div_busy_len", nbusy, DIV_CYC);
      end

      // Reset in the middle of a multiply, then reset racing a start.
      clearInputs();
      md_start = 1'b1;
      applyStimulus();
      md_start = 1'b0;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("rst_mid_busy", md_busy, 0);
      checkOutput("rst_mid_cnt", stall_cnt, 0);
      applyStimulus();
      reset = 1'b1; md_start = 1'b1;
      applyStimulus();
      reset = 1'b0; md_start = 1'b0;
      #1;
      checkOutput("rst_start_busy", md_busy, 0);
      applyStimulus();

      // Saturation of the stall counter.
      clearInputs();
      d_md_use = 1'b1; md_start = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulus();
      #1;
      checkOutput("sat_cnt", stall_cnt, CNT_MAX);
      applyStimulus();

      // Randomized traffic with small address range to provoke matches.
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 39) == 0);
         d_rs      = RA_W'($urandom_range(0, 3));
         d_rt      = RA_W'($urandom_range(0, 3));
         d_tuse_rs = T_W'($urandom_range(0, 3));
         d_tuse_rt = T_W'($urandom_range(0, 3));
         d_md_use  = ($urandom_range(0, 3) == 0);
         e_dest    = RA_W'($urandom_range(0, 3));
         m_dest    = RA_W'($urandom_range(0, 3));
         w_dest    = RA_W'($urandom_range(0, 3));
         e_we      = $urandom_range(0, 1) != 0;
         m_we      = $urandom_range(0, 1) != 0;
         w_we      = $urandom_range(0, 1) != 0;
         e_tnew    = T_W'($urandom_range(0, 3));
         m_tnew    = T_W'($urandom_range(0, 3));
         md_start  = ($urandom_range(0, 9) == 0);
         md_is_div = $urandom_range(0, 1) != 0;
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
